f_pc_fd_reg: RTL and testbench



---
 rtl/f_pc_fd_reg_if.sv | 27 ++
 rtl/f_pc_fd_reg.sv | 85 ++++++++
 tb/tb_f_pc_fd_reg.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/f_pc_fd_reg_if.sv
// Fetch/decode bundle between the F-stage PC register and the rest of the core.
// The master side drives next-PC, fetched word and redirect controls; the slave side returns PCs and D-stage state.
interface f_pc_fd_reg_if;
    logic [31:0] F_newPC;
    logic [31:0] F_Instr;
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] EPC;
    logic        D_isBJ;
    logic [31:0] F_PC;
    logic [4:0]  F_ExcCode;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic [4:0]  D_ExcCode;
    logic        D_BD;

    modport master (
        output F_newPC, F_Instr, stall, req, eret, EPC, D_isBJ,
        input  F_PC, F_ExcCode, D_PC, D_Instr, D_ExcCode, D_BD
    );

    modport slave (
        input  F_newPC, F_Instr, stall, req, eret, EPC, D_isBJ,
        output F_PC, F_ExcCode, D_PC, D_Instr, D_ExcCode, D_BD
    );
endinterface

// File: rtl/f_pc_fd_reg.sv
// Fetch-stage PC register and F/D pipeline register with stall, exception and eret redirects.
// Define FETCH_CNT_EN to add the fetch_cnt/stall_cnt performance counters.
module f_pc_fd_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LAST    = 32'h0000_6FFC
) (
    input  logic          clk,
    input  logic          reset_n,
`ifdef FETCH_CNT_EN
    output logic [31:0]   fetch_cnt,
    output logic [31:0]   stall_cnt,
`endif
    f_pc_fd_reg_if.slave  bus
);

    logic [31:0] pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [4:0]  d_exc;
    logic        d_bd;
    logic        fetch_err;

    // Bad PCs are loaded as-is; the fault only shows up here as AdEL.
    assign fetch_err = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);

    assign bus.F_PC      = pc;
    assign bus.F_ExcCode = fetch_err ? 5'd4 : 5'd0;
    assign bus.D_PC      = d_pc;
    assign bus.D_Instr   = d_instr;
    assign bus.D_ExcCode = d_exc;
    assign bus.D_BD      = d_bd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            d_pc    <= 32'h0;
            d_instr <= 32'h0;
            d_exc   <= 5'd0;
            d_bd    <= 1'b0;
        end else if (bus.req) begin
            // Bubble carries the handler address so the macro-PC never goes backwards.
            pc      <= HANDLER_PC;
            d_pc    <= HANDLER_PC;
            d_instr <= 32'h0;
            d_exc   <= 5'd0;
            d_bd    <= 1'b0;
        end else if (bus.stall) begin
            pc      <= pc;
            d_pc    <= d_pc;
            d_instr <= d_instr;
            d_exc   <= d_exc;
            d_bd    <= d_bd;
        end else if (bus.eret) begin
            pc      <= bus.EPC;
            d_pc    <= bus.EPC;
            d_instr <= 32'h0;
            d_exc   <= 5'd0;
            d_bd    <= 1'b0;
        end else begin
            pc      <= bus.F_newPC;
            d_pc    <= pc;
            d_instr <= fetch_err ? 32'h0 : bus.F_Instr;
            d_exc   <= fetch_err ? 5'd4 : 5'd0;
            d_bd    <= bus.D_isBJ;
        end
    end

`ifdef FETCH_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else if (!bus.req) begin
            if (bus.stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else if (!bus.eret) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_f_pc_fd_reg.sv
// Randomized self-checking bench for f_pc_fd_reg against a behavioural pipeline model.
// Build with FETCH_CNT_EN defined to also check the performance counters.
module tb_f_pc_fd_reg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    f_pc_fd_reg_if bus ();

`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    f_pc_fd_reg dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef FETCH_CNT_EN
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus.slave)
    );

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] mFpc, mDpc, mDinstr;
    logic [4:0]  mDexc;
    logic        mDbd;
    logic [31:0] mFetch, mStall;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // An address is a legal fetch target only when word-aligned and inside instruction memory.
    function automatic logic [4:0] expExc(input logic [31:0] addr);
        if (addr % 4 != 0 || addr < 32'h3000 || addr > 32'h6FFC) return 5'd4;
        return 5'd0;
    endfunction

    task automatic modelReset();
        mFpc = RESET_PC; mDpc = 0; mDinstr = 0; mDexc = 0; mDbd = 0;
        mFetch = 0; mStall = 0;
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".F_PC"},      bus.F_PC,      mFpc);
        checkOutput({where, ".F_ExcCode"}, {27'b0, bus.F_ExcCode}, {27'b0, expExc(mFpc)});
        checkOutput({where, ".D_PC"},      bus.D_PC,      mDpc);
        checkOutput({where, ".D_Instr"},   bus.D_Instr,   mDinstr);
        checkOutput({where, ".D_ExcCode"}, {27'b0, bus.D_ExcCode}, {27'b0, mDexc});
        checkOutput({where, ".D_BD"},      {31'b0, bus.D_BD}, {31'b0, mDbd});
`ifdef FETCH_CNT_EN
        checkOutput({where, ".fetch_cnt"}, fetch_cnt, mFetch);
        checkOutput({where, ".stall_cnt"}, stall_cnt, mStall);
`endif
    endtask

    task automatic applyStimulus(input string where, input logic [31:0] newPc, input logic [31:0] instr,
                                 input logic st, input logic rq, input logic er,
                                 input logic [31:0] epc, input logic isBj);
        logic [4:0] e;
        bus.F_newPC = newPc; bus.F_Instr = instr; bus.stall = st; bus.req = rq;
        bus.eret = er; bus.EPC = epc; bus.D_isBJ = isBj;
        @(posedge clk);
        e = expExc(mFpc);
        if (rq) begin
            mFpc = HANDLER_PC; mDpc = HANDLER_PC; mDinstr = 0; mDexc = 0; mDbd = 0;
        end else if (st) begin
            mStall = mStall + 1;
        end else if (er) begin
            mFpc = epc; mDpc = epc; mDinstr = 0; mDexc = 0; mDbd = 0;
        end else begin
            mDpc = mFpc; mDinstr = (e != 0) ? 32'h0 : instr; mDexc = e; mDbd = isBj;
            mFpc = newPc; mFetch = mFetch + 1;
        end
        #1;
        checkAll(where);
    endtask

    task automatic stepNormal(input string where, input logic isBj);
        applyStimulus(where, mFpc + 32'd4, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, isBj);
    endtask

    logic [31:0] pick;
    logic [31:0] heldInstr;

    initial begin
        bus.F_newPC = 0; bus.F_Instr = 0; bus.stall = 0; bus.req = 0;
        bus.eret = 0; bus.EPC = 0; bus.D_isBJ = 0;
        modelReset();
        #12;
        checkAll("reset");
        reset_n = 1'b1;

        // Sequential fetch from the reset vector.
        stepNormal("seq0", 1'b0);
        checkOutput("seq0.pc", bus.F_PC, 32'h3004);
        stepNormal("seq1", 1'b0);
        stepNormal("seq2", 1'b0);
        stepNormal("seq3", 1'b0);
        checkOutput("seq3.pc", bus.F_PC, 32'h3010);

        heldInstr = bus.D_Instr;
        for (int i = 0; i < 3; i++)
            applyStimulus("stall", mFpc + 4, $urandom, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("stall.held", bus.D_Instr, heldInstr);
        stepNormal("resume", 1'b0);

        while (mFpc != 32'h3020) stepNormal("walk", 1'b0);
        applyStimulus("reqStall", mFpc + 4, $urandom, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("reqStall.pc", bus.F_PC, HANDLER_PC);

        applyStimulus("eret", mFpc + 4, $urandom, 1'b0, 1'b0, 1'b1, 32'h3048, 1'b0);
        checkOutput("eret.pc", bus.F_PC, 32'h3048);
        applyStimulus("eretStall", mFpc + 4, $urandom, 1'b1, 1'b0, 1'b1, 32'h5000, 1'b0);

        applyStimulus("mis", 32'h3002, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus("oor", 32'h7000, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("oor.dexc", {27'b0, bus.D_ExcCode}, 32'd4);
        applyStimulus("last", 32'h6FFC, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus("lastOk", 32'h3100, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("last.fexc", {27'b0, bus.F_ExcCode}, 32'd0);

        stepNormal("bj", 1'b1);
        stepNormal("slot", 1'b0);
        applyStimulus("bjReq", mFpc + 4, $urandom, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("bjReq.bd", {31'b0, bus.D_BD}, 32'd0);

        // Random traffic, with one asynchronous reset dropped in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset_n = 1'b0;
                #2;
                modelReset();
                checkAll("midReset");
                reset_n = 1'b1;
            end
            case ($urandom % 10)
                0: pick = 32'h3000 + (($urandom % 32'h1000) << 2);
                1: pick = 32'h3000 + ($urandom % 32'h4000);
                2: pick = ($urandom % 2) ? 32'h7000 : 32'h2FFC;
                3: pick = $urandom;
                default: pick = mFpc + 4;
            endcase
            applyStimulus("rand", pick, $urandom, ($urandom % 4) == 0, ($urandom % 16) == 0,
                          ($urandom % 12) == 0, 32'h3000 + (($urandom % 32'h100) << 2), $urandom % 2);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
